// File: rtl/modulo_contador_sync_7_bits_descendente.sv
// 7-bit synchronous down counter with clear, preset, parallel load and cascade borrow.
// Define CONTADOR_DESC_RELOAD_EN to add a reload register (programmable divide-by-(rld+1)).
module modulo_contador_sync_7_bits_descendente (
  input  logic       clk,
  input  logic       clr,
  input  logic       prst,
  input  logic       en,
  input  logic       load,
  input  logic [6:0] d,
  output logic [6:0] q,
  output logic       zero,
  output logic       borrow
);

  localparam logic [6:0] CntMax = 7'd127;

  logic [6:0] cnt_q, cnt_d;
  logic [6:0] wrap_val;
  logic       cnt_is_zero;

  assign cnt_is_zero = (cnt_q == 7'd0);

`ifdef CONTADOR_DESC_RELOAD_EN
  logic [6:0] rld_q, rld_d;

  // Reload value follows the same priority as the counter; clr handled in the flop.
  always_comb begin
    rld_d = rld_q;
    if (prst) begin
      rld_d = CntMax;
    end else if (load) begin
      rld_d = d;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rld_q <= CntMax;
    end else begin
      rld_q <= rld_d;
    end
  end

  assign wrap_val = rld_q;
`else
  assign wrap_val = CntMax;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (prst) begin
      cnt_d = CntMax;
    end else if (load) begin
      cnt_d = d;
    end else if (en) begin
      cnt_d = cnt_is_zero ? wrap_val : cnt_q - 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= 7'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q      = cnt_q;
  assign zero   = cnt_is_zero;
  // Terminal count: high only when the coming edge will actually underflow.
  assign borrow = en & cnt_is_zero & ~load & ~prst & ~clr;

endmodule

// File: tb/tb_modulo_contador_sync_7_bits_descendente.sv
// Directed self-checking bench for the 7-bit down counter, including a two-stage cascade.
module tb_modulo_contador_sync_7_bits_descendente;

  logic       clk;
  logic       clr, prst, en, load;
  logic [6:0] d;
  logic [6:0] q;
  logic       zero, borrow;

  logic       clr_c, en_c;
  logic [6:0] lo_q, hi_q;
  logic       lo_zero, hi_zero, lo_borrow, hi_borrow;
  logic       tie0;
  logic [6:0] tie_d;

  int n_total = 0;
  int n_bad   = 0;

  assign tie0  = 1'b0;
  assign tie_d = 7'd0;

  modulo_contador_sync_7_bits_descendente dut (
    .clk    (clk),
    .clr    (clr),
    .prst   (prst),
    .en     (en),
    .load   (load),
    .d      (d),
    .q      (q),
    .zero   (zero),
    .borrow (borrow)
  );

  modulo_contador_sync_7_bits_descendente u_lo (
    .clk    (clk),
    .clr    (clr_c),
    .prst   (tie0),
    .en     (en_c),
    .load   (tie0),
    .d      (tie_d),
    .q      (lo_q),
    .zero   (lo_zero),
    .borrow (lo_borrow)
  );

  modulo_contador_sync_7_bits_descendente u_hi (
    .clk    (clk),
    .clr    (clr_c),
    .prst   (tie0),
    .en     (lo_borrow),
    .load   (tie0),
    .d      (tie_d),
    .q      (hi_q),
    .zero   (hi_zero),
    .borrow (hi_borrow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int exp_q;
  int bad_cascade;
  logic [6:0] hi_prev;
  logic       bor_prev;

  initial begin
    clr = 1'b1; prst = 1'b0; en = 1'b0; load = 1'b0; d = 7'd0;
    clr_c = 1'b1; en_c = 1'b0;
    #1;

    // Reset state
    step();
    check("rst_q", q, 0);
    check("rst_zero", zero, 1);
    check("rst_borrow", borrow, 0);

    // Clear with q=55 and en=1, then count through underflow
    clr = 1'b0; load = 1'b1; d = 7'd55;
    step();
    check("load55", q, 55);
    load = 1'b0; clr = 1'b1; en = 1'b1;
    step();
    check("clr_q", q, 0);
    check("clr_zero", zero, 1);
    check("clr_borrow", borrow, 0);
    clr = 1'b0;
    #1;
    check("borrow_at0", borrow, 1);
    step();
    check("after_clr_1", q, 127);
    check("borrow_off", borrow, 0);
    step();
    check("after_clr_2", q, 126);
    step();
    check("after_clr_3", q, 125);

    // Load 3 and count through underflow
    load = 1'b1; d = 7'd3; en = 1'b1;
    step();
    check("ld3_q", q, 3);
    check("ld3_zero", zero, 0);
    load = 1'b0;
    step();
    check("ld3_2", q, 2);
    step();
    check("ld3_1", q, 1);
    step();
    check("ld3_0", q, 0);
    check("ld3_zero0", zero, 1);
    check("ld3_borrow0", borrow, 1);
    step();
`ifdef CONTADOR_DESC_RELOAD_EN
    check("ld3_wrap", q, 3);
`else
    check("ld3_wrap", q, 127);
`endif
    check("ld3_zero_wrap", zero, 0);
    step();
`ifdef CONTADOR_DESC_RELOAD_EN
    check("ld3_after", q, 2);
`else
    check("ld3_after", q, 126);
`endif

    // Enable toggling from 10
    load = 1'b1; d = 7'd10; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    step();
    check("en_t1", q, 9);
    en = 1'b0;
    step();
    check("en_t2", q, 9);
    step();
    check("en_t3", q, 9);
    check("en_off_borrow", borrow, 0);
    en = 1'b1;
    step();
    check("en_t4", q, 8);

    // Priority: clr > prst > load
    en = 1'b0; clr = 1'b1; prst = 1'b1; load = 1'b1; d = 7'd20;
    step();
    check("pri_clr", q, 0);
    clr = 1'b0; en = 1'b1;
    #1;
    check("pri_borrow_masked", borrow, 0);
    en = 1'b0;
    step();
    check("pri_prst", q, 127);
    prst = 1'b0;
    step();
    check("pri_load", q, 20);
    load = 1'b0;

    // clr raised between edges must not act until the edge
    clr = 1'b1;
    #2;
    check("clr_sync_hold", q, 20);
    step();
    check("clr_sync_edge", q, 0);
    clr = 1'b0;

    // Two-stage cascade
    step();
    clr_c = 1'b0; en_c = 1'b1;
    step();
    check("casc_lo_1", lo_q, 127);
    check("casc_hi_1", hi_q, 127);
    bad_cascade = 0;
    for (int i = 0; i < 128; i++) begin
      hi_prev  = hi_q;
      bor_prev = lo_borrow;
      step();
      if ((hi_q != hi_prev) != bor_prev) bad_cascade++;
    end
    check("casc_lo_129", lo_q, 127);
    check("casc_hi_129", hi_q, 126);
    check("casc_hi_only_on_borrow", bad_cascade, 0);
    en_c = 1'b0;

`ifdef CONTADOR_DESC_RELOAD_EN
    // Programmable divide-by-5
    load = 1'b1; d = 7'd4; en = 1'b0;
    step();
    load = 1'b0; en = 1'b1;
    exp_q = 4;
    for (int i = 0; i < 20; i++) begin
      check("div5_borrow", borrow, (exp_q == 0) ? 1 : 0);
      step();
      exp_q = (exp_q == 0) ? 4 : exp_q - 1;
      check("div5_q", q, exp_q);
    end
    clr = 1'b1;
    step();
    check("div5_clr", q, 0);
    clr = 1'b0;
    step();
    check("div5_rld_reset", q, 127);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/modulo_contador_sync_7_bits_descendente.md
MODULO_CONTADOR_SYNC_7_BITS_DESCENDENTE -- requirements
Module: modulo_contador_sync_7_bits_descendente

Interface
REQ-001 Parameters: none; counter width SHALL be fixed at 7 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-003 clr  input  1  reset; synchronous, active-high.
REQ-004 prst  input  1  synchronous, active-high preset to all ones.
REQ-005 en  input  1  count enable; active-high.
REQ-006 load  input  1  synchronous parallel load strobe; active-high.
REQ-007 d  input  7  parallel load value.
REQ-008 q  output  7  registered counter value.
REQ-009 zero  output  1  combinational flag; high when q == 0.
REQ-010 borrow  output  1  combinational terminal-count flag for cascading; high when the next edge underflows.

Function
REQ-011 Per-edge priority SHALL be clr > prst > load > en count > hold.
REQ-012 prst SHALL set q = 7'd127 on the next edge.
REQ-013 load SHALL set q = d on the next edge, regardless of en.
REQ-014 With en=1 and no higher-priority input, q SHALL decrement by exactly 1 per edge when q != 0; latency is one cycle from en sampled high to the new q.
REQ-015 With en=1 and q == 0, the next q SHALL be the underflow value: 7'd127 in the base build, or the reload value (REQ-024) in the macro build.
REQ-016 With en=0 and no clr, prst or load, q SHALL hold.
REQ-017 zero SHALL equal (q == 0) and is independent of en.
REQ-018 borrow SHALL equal en & (q == 0) & ~load & ~prst & ~clr, so it is high exactly in the cycle before an underflow edge.
REQ-019 Cascading is supported: the borrow of a lower stage drives the en of the next stage, and both stages share clk. The chained count SHALL then be a synchronous 14-bit down count with no extra latency.
REQ-020 Arithmetic SHALL be modulo 128 and SHALL produce no X or out-of-range states.

Reset
REQ-021 clr high at a rising edge SHALL force q = 0. zero then reads 1 and borrow reads 0, because clr is in the borrow term.
REQ-022 clr SHALL override prst, load and en in the same cycle, including mid-count and at the underflow point.
REQ-023 No asynchronous path SHALL exist; when clr is asserted between edges, q SHALL not change until the next edge.

Configuration
REQ-024 When macro CONTADOR_DESC_RELOAD_EN is defined, the block SHALL include a 7-bit reload register rld, and:
  - clr and prst SHALL set rld = 7'd127;
  - load SHALL capture d into both q and rld;
  - on underflow (REQ-015), q SHALL take rld.
  This makes the block a programmable divide-by-(rld+1).
REQ-025 When CONTADOR_DESC_RELOAD_EN is undefined:
  - no reload register SHALL exist;
  - the underflow value SHALL be 7'd127 (free-running modulo 128);
  - load SHALL affect only q.
REQ-026 Ports SHALL be identical in both builds.

Verification
REQ-027 clr=1 for one edge with q=7'd55, en=1 -> q=0, zero=1, borrow=0. Then clr=0, en=1 for 3 edges -> q=127, 126, 125, with borrow=1 only in the cycle when q was 0.
REQ-028 load=1, d=7'd3, en=1, then load=0 with en=1 for 5 edges -> q = 3, 2, 1, 0, then the underflow value (127 base; 3 macro), then 126 base or 2 macro. zero=1 only while q=0.
REQ-029 q=7'd10 with en toggling 1,0,0,1 -> q = 9, 9, 9, 8.
REQ-030 clr, prst and load asserted together with d=7'd20 -> q=0. Then prst and load with d=20 -> q=127. Then load alone -> q=20.
REQ-031 Two stages cascaded, lower borrow driving upper en, both cleared, lower en=1 -> after 1 edge the pair reads {127,127}. After 128 further edges it reads {126,127}; the upper stage changes only on edges where the lower borrow was 1.
REQ-032 Macro build only: load d=7'd4, then run en=1 for 20 edges -> q repeats 4,3,2,1,0 with period 5; borrow pulses every 5th cycle. clr mid-sequence -> q=0 and rld=127, so the next underflow yields 127.
